frame_generator: RTL

Parametrised successor to the fixed single-ARP frame sender for the delay tester. It generates a stream of Ethernet frames over the byte-serial MAC TX interface (`mac_tx_data` / `mac_tx_dvld` / `mac_tx_ack`). Frame length, inter-frame gap, frame count and header fields are configurable, and every frame carries a sequence number and a TX timestamp so the receive side can measure delay and loss. It sits between the test controller (`enable`) and the MAC TX port and drives the MAC configuration pins.

---
 rtl/frame_gen_pkg.sv | 32 +++
 rtl/frame_byte_sel.sv | 39 +++
 rtl/frame_generator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg: shared definitions for the delay-tester frame generator.
//   - state_e      : generator FSM states
//   - OFF_*        : byte offsets of the header fields within a frame
//   - ETH_TYPE_*   : common EtherType values
//   - MAC_NF2C*    : NetFPGA port MAC addresses
package frame_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        SEND,
        GAP,
        DONE
    } state_e;

    localparam int OFF_DST  = 0;
    localparam int OFF_SRC  = 6;
    localparam int OFF_TYPE = 12;
    localparam int OFF_SEQ  = 14;
    localparam int OFF_TS   = 18;
    localparam int OFF_PAY  = 22;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_RARP = 16'h8035;
    localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
    localparam logic [15:0] ETH_TYPE_88B5 = 16'h88B5;

    localparam logic [47:0] MAC_NF2C0 = 48'h004e46324300;
    localparam logic [47:0] MAC_NF2C1 = 48'h004e46324301;

endpackage

// File: rtl/frame_byte_sel.sv
// frame_byte_sel: combinational selection of one frame byte.
// Ports:
//   idx_i  : byte index within the frame
//   seq_i  : sequence number carried in bytes OFF_SEQ..OFF_SEQ+3
//   ts_i   : timestamp carried in bytes OFF_TS..OFF_TS+3
//   byte_o : frame byte at idx_i (header big-endian, then (idx-OFF_PAY) mod 256)
module frame_byte_sel
    import frame_gen_pkg::*;
#(
    parameter int          IDX_W    = 6,
    parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC  = MAC_NF2C0,
    parameter logic [15:0] ETH_TYPE = ETH_TYPE_88B5
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      seq_i,
    input  logic [31:0]      ts_i,
    output logic [7:0]       byte_o
);

    // Whole header as one vector, byte 0 in the top bits.
    logic [175:0] hdr;
    logic [31:0]  idx32;
    logic         in_hdr;
    logic [7:0]   hdr_lsb;
    logic [7:0]   pay;

    assign hdr    = {DST_MAC, SRC_MAC, ETH_TYPE, seq_i, ts_i};
    assign idx32  = 32'(idx_i);
    assign in_hdr = idx32 < 32'(OFF_PAY);

    // Bit position of header byte idx; held at 0 in the payload so the
    // part-select never leaves the vector.
    assign hdr_lsb = in_hdr ? 8'(32'((OFF_PAY - 1) * 8) - (idx32 << 3)) : 8'd0;
    assign pay     = idx32[7:0] - 8'(OFF_PAY);

    assign byte_o = in_hdr ? hdr[hdr_lsb +: 8] : pay;

endmodule

// File: rtl/frame_generator.sv
// frame_generator: emits a stream of Ethernet test frames on the byte-serial
// MAC TX interface. Each frame carries a sequence number and the TX timestamp
// captured when the MAC acknowledged the first byte.
// Ports:
//   tx_clk, reset        : clock, synchronous active-high reset
//   enable               : run frames while high (level)
//   conf_tx_en           : MAC TX enable (registered, 1 after reset)
//   conf_tx_jumbo_en     : 1 when FRAME_LEN > 1514 (registered)
//   conf_tx_no_gen_crc   : 0, the MAC appends the CRC
//   mac_tx_data/_dvld    : frame byte / valid
//   mac_tx_ack           : MAC accepted byte 0 (only honoured in WAIT_ACK)
//   frames_sent          : completed frames since reset, wraps
//   busy, done           : in WAIT_ACK/SEND, in DONE
module frame_generator
    import frame_gen_pkg::*;
#(
    parameter int          FRAME_LEN  = 60,
    parameter int          GAP_CYCLES = 100,
    parameter int          NUM_FRAMES = 0,
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = MAC_NF2C0,
    parameter logic [15:0] ETH_TYPE   = ETH_TYPE_88B5
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        enable,
    output logic        conf_tx_en,
    output logic        conf_tx_jumbo_en,
    output logic        conf_tx_no_gen_crc,
    output logic [7:0]  mac_tx_data,
    output logic        mac_tx_dvld,
    input  logic        mac_tx_ack,
    output logic [31:0] frames_sent,
    output logic        busy,
    output logic        done
);

    localparam int               IDX_W      = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_LEN - 1);
    localparam logic [31:0]      GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]      NUM_TARGET = 32'(NUM_FRAMES);
    localparam logic             JUMBO      = (FRAME_LEN > 1514);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [31:0]      gap_q,    gap_d;
    logic [31:0]      ts_q;
    logic [31:0]      ts_cap_q, ts_cap_d;
    logic [31:0]      frames_q, frames_d;
    logic [31:0]      batch_q,  batch_d;
    logic             tx_en_q;
    logic             jumbo_q;
    logic [7:0]       sel_byte;

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            ts_q     <= '0;
            ts_cap_q <= '0;
            frames_q <= '0;
            batch_q  <= '0;
            tx_en_q  <= 1'b0;
            jumbo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            ts_q     <= ts_q + 32'd1;
            ts_cap_q <= ts_cap_d;
            frames_q <= frames_d;
            batch_q  <= batch_d;
            tx_en_q  <= 1'b1;
            jumbo_q  <= JUMBO;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        ts_cap_d = ts_cap_q;
        frames_d = frames_q;
        batch_d  = batch_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Byte 0 is presented here; the ack cycle fixes the timestamp.
                if (mac_tx_ack) begin
                    state_d  = SEND;
                    idx_d    = IDX_W'(1);
                    ts_cap_d = ts_q;
                end
            end
            SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d  = GAP;
                    idx_d    = '0;
                    gap_d    = '0;
                    frames_d = frames_q + 32'd1;
                    batch_d  = batch_q + 32'd1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if ((NUM_FRAMES != 0) && (batch_q == NUM_TARGET)) state_d = DONE;
                    else if (enable)                                  state_d = WAIT_ACK;
                    else                                              state_d = IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            DONE: begin
                // Re-arm only after enable has been released.
                if (!enable) begin
                    state_d = IDLE;
                    batch_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    frame_byte_sel #(
        .IDX_W    (IDX_W),
        .DST_MAC  (DST_MAC),
        .SRC_MAC  (SRC_MAC),
        .ETH_TYPE (ETH_TYPE)
    ) u_byte_sel (
        .idx_i  (idx_q),
        .seq_i  (frames_q),
        .ts_i   (ts_cap_q),
        .byte_o (sel_byte)
    );

    assign mac_tx_dvld        = (state_q == WAIT_ACK) || (state_q == SEND);
    assign mac_tx_data        = mac_tx_dvld ? sel_byte : 8'h00;
    assign busy               = mac_tx_dvld;
    assign done               = (state_q == DONE);
    assign frames_sent        = frames_q;
    assign conf_tx_en         = tx_en_q;
    assign conf_tx_jumbo_en   = jumbo_q;
    assign conf_tx_no_gen_crc = 1'b0;

endmodule
